// File: rtl/branch_pkg.sv
// Shared constants for the EX-stage branch controller: opcodes, condition-mux
// select encoding and controller FSM states.
package branch_pkg;

   localparam int unsigned OP_W  = 6;
   localparam int unsigned SEL_W = 2;

   localparam logic [OP_W-1:0] OP_BEQ = 6'h04;
   localparam logic [OP_W-1:0] OP_BGE = 6'h01;
   localparam logic [OP_W-1:0] OP_BGT = 6'h07;
   localparam logic [OP_W-1:0] OP_BNE = 6'h05;

   typedef enum logic [SEL_W-1:0] {
      SEL_BEQ = 2'd0,
      SEL_BGE = 2'd1,
      SEL_BGT = 2'd2,
      SEL_BNE = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_FLUSH1 = 2'd1,
      ST_FLUSH2 = 2'd2
   } state_e;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition decode: opcode plus ALU flags to
// condition-mux select, taken and legal indications.
module branch_cond
   import branch_pkg::*;
(
   input  logic [OP_W-1:0] op_i,
   input  logic            zero_i,
   input  logic            sign_i,
   output sel_e            select_c_o,
   output logic            taken_c_o,
   output logic            legal_c_o
);

   always_comb begin
      select_c_o = SEL_BEQ;
      taken_c_o  = 1'b0;
      legal_c_o  = 1'b1;
      case (op_i)
         OP_BEQ: begin
            select_c_o = SEL_BEQ;
            taken_c_o  = zero_i;
         end
         OP_BGE: begin
            select_c_o = SEL_BGE;
            taken_c_o  = !sign_i;
         end
         OP_BGT: begin
            select_c_o = SEL_BGT;
            taken_c_o  = !sign_i && !zero_i;
         end
         OP_BNE: begin
            select_c_o = SEL_BNE;
            taken_c_o  = !zero_i;
         end
         default: legal_c_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// EX-stage branch resolution: one-cycle redirect, two-cycle pipeline flush,
// illegal-opcode pulse and saturating branch/taken statistics.
module branch_ctrl
   import branch_pkg::*;
#(
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              valid_i,
   input  logic              branch_i,
   input  logic [OP_W-1:0]   op_i,
   input  logic              zero_i,
   input  logic              sign_i,
   input  logic [ADDR_W-1:0] target_i,
   input  logic              stall_i,
   output logic [SEL_W-1:0]  select_o,
   output logic              pc_src_o,
   output logic [ADDR_W-1:0] target_o,
   output logic              flush_o,
   output logic              illegal_o,
   output logic [CNT_W-1:0]  branch_cnt_o,
   output logic [CNT_W-1:0]  taken_cnt_o
);

   state_e              state_q, state_d;
   sel_e                select_q, select_d;
   logic                pc_src_q, pc_src_d;
   logic [ADDR_W-1:0]   target_q, target_d;
   logic                flush_q, flush_d;
   logic                illegal_q, illegal_d;
   logic [CNT_W-1:0]    branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0]    taken_cnt_q, taken_cnt_d;

   sel_e                cond_sel;
   logic                cond_taken;
   logic                cond_legal;

   branch_cond u_cond (
      .op_i       (op_i),
      .zero_i     (zero_i),
      .sign_i     (sign_i),
      .select_c_o (cond_sel),
      .taken_c_o  (cond_taken),
      .legal_c_o  (cond_legal)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         select_q     <= SEL_BEQ;
         pc_src_q     <= 1'b0;
         target_q     <= '0;
         flush_q      <= 1'b0;
         illegal_q    <= 1'b0;
         branch_cnt_q <= '0;
         taken_cnt_q  <= '0;
      end else begin
         state_q      <= state_d;
         select_q     <= select_d;
         pc_src_q     <= pc_src_d;
         target_q     <= target_d;
         flush_q      <= flush_d;
         illegal_q    <= illegal_d;
         branch_cnt_q <= branch_cnt_d;
         taken_cnt_q  <= taken_cnt_d;
      end
   end

   // A stall freezes every register, so a pending redirect is re-presented afterwards.
   always_comb begin
      state_d      = state_q;
      select_d     = select_q;
      pc_src_d     = pc_src_q;
      target_d     = target_q;
      illegal_d    = illegal_q;
      branch_cnt_d = branch_cnt_q;
      taken_cnt_d  = taken_cnt_q;
      if (!stall_i) begin
         pc_src_d  = 1'b0;
         illegal_d = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (valid_i && branch_i) begin
                  if (cond_legal) begin
                     select_d = cond_sel;
                     target_d = target_i;
                     if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
                     if (cond_taken) begin
                        pc_src_d = 1'b1;
                        state_d  = ST_FLUSH1;
                        if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_W'(1);
                     end
                  end else begin
                     select_d  = SEL_BEQ;
                     illegal_d = 1'b1;
                  end
               end
            end
            ST_FLUSH1: state_d = ST_FLUSH2;
            ST_FLUSH2: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
         endcase
      end
      flush_d = (state_d != ST_IDLE);
   end

   assign select_o     = select_q;
   assign pc_src_o     = pc_src_q;
   assign target_o     = target_q;
   assign flush_o      = flush_q;
   assign illegal_o    = illegal_q;
   assign branch_cnt_o = branch_cnt_q;
   assign taken_cnt_o  = taken_cnt_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the branch and taken statistics counters.
REQ-002 Parameter ADDR_W, default 32, width of the branch target address.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 valid_i  input  1  the EX-stage slot holds a live instruction.
REQ-006 branch_i  input  1  the EX-stage instruction is a conditional branch.
REQ-007 op_i  input  6  opcode of the EX-stage instruction.
REQ-008 zero_i  input  1  ALU flag, rs-rt equals 0.
REQ-009 sign_i  input  1  ALU flag, rs-rt is negative.
REQ-010 target_i  input  ADDR_W  computed branch target.
REQ-011 stall_i  input  1  pipeline stall; freezes this block.
REQ-012 select_o  output  2  registered branch-type encoding for the downstream 4:1 condition mux: 0 beq, 1 bge, 2 bgt, 3 bne.
REQ-013 pc_src_o  output  1  redirect the PC to target_o.
REQ-014 target_o  output  ADDR_W  registered redirect address.
REQ-015 flush_o  output  1  squash the IF/ID and ID/EX registers.
REQ-016 illegal_o  output  1  one-cycle pulse for a branch with an unknown opcode.
REQ-017 branch_cnt_o  output  CNT_W  count of resolved legal branches.
REQ-018 taken_cnt_o  output  CNT_W  count of taken branches.

Function
REQ-019 An instruction is accepted on a rising edge when valid_i=1, branch_i=1, stall_i=0 and the FSM is IDLE.
REQ-020 Opcode encoding: 6'h04 maps to select 0 (beq), 6'h01 to 1 (bge), 6'h07 to 2 (bgt), 6'h05 to 3 (bne).
REQ-021 Taken conditions: beq = zero_i; bge = !sign_i; bgt = !sign_i & !zero_i; bne = !zero_i.
REQ-022 Latency is 1 cycle: select_o, pc_src_o and target_o reflect the instruction accepted at edge N during cycle N+1.
REQ-023 pc_src_o is high for exactly one unstalled cycle per taken branch; it is low otherwise.
REQ-024 The FSM has three states: IDLE, FLUSH1 and FLUSH2.
REQ-025 FSM transitions: a taken accept moves IDLE to FLUSH1; FLUSH1 moves to FLUSH2; FLUSH2 moves to IDLE.
REQ-026 flush_o = 1 in FLUSH1 and FLUSH2, and 0 in IDLE.
REQ-027 In FLUSH1 and FLUSH2, valid_i and branch_i are ignored: no accept, no count, no illegal_o.
REQ-028 A not-taken branch leaves the FSM in IDLE, holds pc_src_o at 0, and still updates select_o.
REQ-029 A branch with an unknown opcode sets select_o=0, pc_src_o=0 and illegal_o=1 for one cycle, and increments no counter.
REQ-030 branch_cnt_o increments by 1 on each legal accept.
REQ-031 taken_cnt_o increments by 1 on each taken accept.
REQ-032 Both counters saturate at all-ones and do not wrap.
REQ-033 When stall_i=1, all registers hold, including FSM state, pc_src_o, target_o, flush_o and the counters.
REQ-034 A pending redirect that is stalled is presented again after the stall and is never lost.
REQ-035 A non-branch instruction (branch_i=0) or an invalid slot (valid_i=0) leaves all state unchanged except that illegal_o and pc_src_o return to 0.
REQ-036 Back-to-back branches: a branch arriving in the cycle right after a taken branch falls inside FLUSH1 and is discarded, per REQ-027.

Reset
REQ-037 While rst_i is high: FSM=IDLE, select_o=0, pc_src_o=0, target_o=0, flush_o=0, illegal_o=0, both counters=0.
REQ-038 Reset asserted mid-flush aborts the flush immediately, asynchronously.
REQ-039 The first accept after reset release occurs at the first rising edge with rst_i low.

Structure
REQ-040 Opcode constants, the select encoding (SEL_BEQ..SEL_BNE) and the FSM state encoding live in the shared package branch_pkg.
REQ-041 The condition evaluation (op, zero, sign -> select, taken, legal) is a combinational sub-module branch_cond, instantiated once.

Verification
REQ-042 Scenario: op 04, zero_i=1, target 0x0000_0040 -> next cycle: select_o=0, pc_src_o=1, target_o=0x40; flush_o=1 for 2 cycles; taken_cnt_o=1.
REQ-043 Scenario: op 07, zero_i=1, sign_i=0 -> select_o=2, pc_src_o=0, flush_o=0, branch_cnt_o=1, taken_cnt_o=0.
REQ-044 Scenario: taken bne, then a taken beq presented in the next cycle -> only one redirect, branch_cnt_o=1.
REQ-045 Scenario: taken bge with stall_i raised in the result cycle for 3 cycles -> pc_src_o stays 1 for those 3 cycles, then the FSM resumes at FLUSH2 sequencing.
REQ-046 Scenario: branch_i=1 with op 6'h3F -> illegal_o pulses for 1 cycle, counters unchanged.
REQ-047 Scenario: preload taken_cnt_o to 0xFFFF with taken branches, then issue one more -> value stays 0xFFFF; assert rst_i during FLUSH1 -> all outputs 0 at once.
